uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

8N1 UART receiver with a small first-word-fall-through byte FIFO; the receive-side counterpart of the debug UART transmitter on the camera board. It runs in the 12 MHz system domain and samples the host-to-board serial line at mid-bit with 3-sample majority voting. It delivers bytes over a valid/ready handshake and reports framing errors and overruns as single-cycle pulses. It is the front end for host commands (e.g. triggering a frame dump) without a button press.

## Interface
- CLKS_PER_BIT, 104, system clocks per UART bit (115200 baud at 12 MHz); legal range ≥ 8.
- FIFO_AW, 2, FIFO address width; depth = 2^FIFO_AW (default 4 bytes).
- sys_clk_i  in  1  system clock, 12 MHz.
- sys_rst_i  in  1  reset, asynchronous, active-high.
- uart_rx_i  in  1  serial input; asynchronous, idle high.
- rx_dat_o  out  8  FIFO head byte; valid only while rx_valid_o = 1.
- rx_valid_o  out  1  FIFO non-empty.
- rx_ready_i  in  1  consumer accepts head when rx_valid_o && rx_ready_i at a clock edge.
- rx_frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- rx_overrun_o  out  1  one-cycle pulse: good byte dropped because FIFO full.
- rx_busy_o  out  1  receiver FSM not in IDLE.

## Operation
- Input synchronizer: two flops, reset to 1; FSM sees only rx_s (second flop).
- H = CLKS_PER_BIT/2 (integer division). Bit counter cnt runs 0..CLKS_PER_BIT-1 and wraps. Samples are taken at cnt = H-1, H, H+1. Majority decision at cnt = H+1.
- States:
  - IDLE: rx_s = 0 → START, cnt = 0.
  - START: decision = 1 → IDLE (false start; no pulse). Decision = 0 → continue; at cnt wrap → DATA, bit index 0.
  - DATA: 8 bits, LSB first, shifted in at each decision. At cnt wrap after bit 7 → STOP.
  - STOP, decision = 1 with FIFO not full, or full with a simultaneous pop → push byte, go to IDLE at that edge.
  - STOP, decision = 1 with FIFO full and no pop → rx_overrun_o pulse, byte dropped, go to IDLE.
  - STOP, decision = 0 → rx_frame_err_o pulse, byte dropped, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s = 1 → IDLE. A break condition does not generate spurious starts.
- FIFO: circular, pointers FIFO_AW bits wrap naturally, count FIFO_AW+1 bits.
  - Push and pop in the same cycle: count unchanged, both succeed (full included).
  - Pop when empty: ignored.
  - rx_dat_o is the head entry combinationally from the registered array. It is undefined (don't-care) when empty.
- rx_busy_o = 1 in START, DATA, STOP, WAIT_HIGH.
- Reset (any time, including mid-byte): FSM → IDLE; cnt, shift register, pointers and count = 0; synchronizer = 1. Any partial byte and all FIFO contents are discarded.
- Reset values: rx_dat_o = 0, rx_valid_o = 0, rx_frame_err_o = 0, rx_overrun_o = 0, rx_busy_o = 0.

## Timing
- Edge 0 = first sys_clk_i edge that captures uart_rx_i = 0 in sync flop 1. rx_s = 0 after edge 1. FSM enters START (cnt = 0) at edge 2.
- Push occurs at edge 2 + 9·CLKS_PER_BIT + H + 1. If the FIFO was empty, rx_valid_o is high after that edge. Default values: edge 991.
- rx_frame_err_o and rx_overrun_o are asserted for exactly the one cycle following the decision edge.
- IDLE is re-entered at stop-bit mid-point. This gives tolerance to ±(H−1)/(10·CLKS_PER_BIT) rate mismatch, ≈ ±4.9% at the default.
- Pop: head advances at the accepting edge. The new head (or rx_valid_o = 0) is visible the next cycle.
- Sustained throughput: one byte per 10·CLKS_PER_BIT cycles; consumer may hold rx_ready_i = 1 permanently.

## Test plan
- Send 0x55, then 0xA3, 104 clks/bit, rx_ready_i = 1 → rx_valid_o high the single cycle after edge 991 with rx_dat_o = 0x55. Then 0xA3 likewise. No error pulses.
- 30-cycle low glitch on idle line → rx_busy_o pulses, returns to IDLE by cnt = H+1. No valid, no frame_err.
- 0xA3 with stop bit low, line held low 500 cycles, then high, then 0x3C → one rx_frame_err_o pulse, no valid, rx_busy_o high through the low period. 0x3C received correctly.
- rx_ready_i = 0, send 0x01..0x05 → rx_valid_o stays high, one rx_overrun_o pulse at the 5th stop decision. Then ready = 1 pops 0x01, 0x02, 0x03, 0x04, and rx_valid_o falls.
- FIFO full (0x01..0x04), rx_ready_i raised exactly on the 5th (0x05) push edge → no overrun. Pops yield 0x02..0x05.
- sys_rst_i pulsed mid-DATA of 0x77, then sender at 100 and 108 clks/bit sends 0xC6, 0x39 → 0x77 never appears. 0xC6 and 0x39 received intact, all outputs 0 during reset.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_rx_fifo : 8N1 UART receiver (mid-bit 3-sample vote) with FWFT byte FIFO
// Revision     : 1.0
// ============================================================================
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_AW      = 2
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] rx_dat_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_frame_err_o,
  output logic       rx_overrun_o,
  output logic       rx_busy_o
);

  localparam int              HALF     = CLKS_PER_BIT / 2;
  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam int              DEPTH    = 1 << FIFO_AW;
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   SMP0     = CW'(HALF - 1);
  localparam logic [CW-1:0]   SMP1     = CW'(HALF);
  localparam logic [CW-1:0]   DECIDE   = CW'(HALF + 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  logic                sync1_q, sync2_q;
  logic                rx_s;
  state_t              state_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                cnt_wrap, decide, vote;
  logic [1:0]          smp_q;
  logic [2:0]          bit_idx_q;
  logic [7:0]          shift_q;
  logic                frame_err_q, overrun_q;

  logic [7:0]          mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    count_q;
  logic                fifo_full, push, pop;

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // cnt_d is the count value a given edge establishes; sample points refer to it
  always_comb begin
    cnt_wrap = (cnt_q == CNT_LAST);
    cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    decide   = (cnt_d == DECIDE);
    vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  end

  assign rx_valid_o = (count_q != '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = rx_valid_o && rx_ready_i;
  assign push       = (state_q == S_STOP) && decide && vote && (!fifo_full || pop);
  assign rx_dat_o   = mem_q[rd_ptr_q];

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      smp_q       <= 2'b11;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (cnt_d == SMP0) smp_q[0] <= rx_s;
      if (cnt_d == SMP1) smp_q[1] <= rx_s;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= S_START;
        end
        S_START: begin
          cnt_q <= cnt_d;
          if (decide && vote) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_wrap) begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
          end
        end
        S_DATA: begin
          cnt_q <= cnt_d;
          if (decide) shift_q <= {vote, shift_q[7:1]};
          if (cnt_wrap) begin
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
            bit_idx_q <= bit_idx_q + 1'b1;
          end
        end
        S_STOP: begin
          cnt_q <= cnt_d;
          if (decide) begin
            cnt_q <= '0;
            if (vote) begin
              overrun_q <= fifo_full && !pop;
              state_q   <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          // a held-low break must not be mistaken for a new start bit
          if (rx_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign rx_frame_err_o = frame_err_q;
  assign rx_overrun_o   = overrun_q;
  assign rx_busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_rx_fifo : randomized bench for uart_rx_fifo against a queue model
// Revision        : 1.0
// ============================================================================
module tb_uart_rx_fifo;

  localparam int CPB   = 104;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rdy = 1'b0;
  logic [7:0] rx_dat;
  logic       rx_valid, rx_frame_err, rx_overrun, rx_busy;

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int fe_cnt = 0, ov_cnt = 0;
  int exp_fe = 0, exp_ov = 0;
  logic [7:0] exp_q[$];
  logic done;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .sys_clk_i      (clk),
    .sys_rst_i      (rst),
    .uart_rx_i      (uart_rx),
    .rx_dat_o       (rx_dat),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (rdy),
    .rx_frame_err_o (rx_frame_err),
    .rx_overrun_o   (rx_overrun),
    .rx_busy_o      (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (cpb) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (cpb) tick();
    end
    uart_rx = stop_bit;
    repeat (cpb) tick();
  endtask

  // Model: a good byte lands if the FIFO has room (or a pop coincides), else overrun
  task automatic model_byte(input logic [7:0] b, input logic stop_ok, input logic pop_at_push);
    if (!stop_ok) exp_fe++;
    else if (exp_q.size() < DEPTH || pop_at_push) exp_q.push_back(b);
    else exp_ov++;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rdy) begin
        if (exp_q.size() == 0) check("pop_extra", 32'(rx_valid), 32'd0);
        else check("pop_data", 32'(rx_dat), 32'(exp_q.pop_front()));
      end
      if (rx_frame_err) fe_cnt <= fe_cnt + 1;
      if (rx_overrun)   ov_cnt <= ov_cnt + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [7:0] b;

    // reset values
    repeat (3) tick();
    check("rst_dat",   32'(rx_dat), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_fe",    32'(rx_frame_err), 32'd0);
    check("rst_ov",    32'(rx_overrun), 32'd0);
    check("rst_busy",  32'(rx_busy), 32'd0);
    rst = 1'b0;
    repeat (5) tick();

    // 0x55 then 0xA3, first-push latency
    rdy = 1'b1;
    t0  = cyc;
    fork
      begin
        model_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'h55, CPB, 1'b1);
        model_byte(8'hA3, 1'b1, 1'b0);
        send_byte(8'hA3, CPB, 1'b1);
      end
      begin
        int seen;
        seen = -1;
        for (int i = 0; i < 1200; i++) begin
          @(negedge clk);
          if (rx_valid) begin
            seen = cyc;
            break;
          end
        end
        check("t_first_valid", 32'(seen), 32'(t0 + 1 + (2 + 9 * CPB + CPB / 2 + 1)));
        @(negedge clk);
        check("valid_1cyc", 32'(rx_valid), 32'd0);
      end
    join
    drain("drain_basic");
    check("basic_fe", 32'(fe_cnt), 32'(exp_fe));
    check("basic_ov", 32'(ov_cnt), 32'(exp_ov));

    // 30-cycle glitch is a false start
    repeat (20) tick();
    uart_rx = 1'b0;
    repeat (30) tick();
    check("glitch_busy", 32'(rx_busy), 32'd1);
    uart_rx = 1'b1;
    repeat (30) tick();
    check("glitch_idle", 32'(rx_busy), 32'd0);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    check("glitch_fe", 32'(fe_cnt), 32'(exp_fe));

    // framing error, long break, then good byte
    repeat (CPB) tick();
    model_byte(8'hA3, 1'b0, 1'b0);
    send_byte(8'hA3, CPB, 1'b0);
    repeat (500) tick();
    check("break_busy", 32'(rx_busy), 32'd1);
    check("break_fe", 32'(fe_cnt), 32'(exp_fe));
    uart_rx = 1'b1;
    repeat (CPB) tick();
    check("break_idle", 32'(rx_busy), 32'd0);
    model_byte(8'h3C, 1'b1, 1'b0);
    send_byte(8'h3C, CPB, 1'b1);
    drain("drain_fe");
    check("fe_total", 32'(fe_cnt), 32'(exp_fe));

    // overrun with consumer stalled
    rdy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      model_byte(8'(k), 1'b1, 1'b0);
      send_byte(8'(k), CPB, 1'b1);
    end
    repeat (10) tick();
    check("ov_valid_held", 32'(rx_valid), 32'd1);
    check("ov_count", 32'(ov_cnt), 32'(exp_ov));
    rdy = 1'b1;
    drain("drain_ov");
    tick();
    check("ov_valid_fall", 32'(rx_valid), 32'd0);

    // full FIFO, pop coincides with fifth push
    rdy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      model_byte(8'(k), 1'b1, 1'b0);
      send_byte(8'(k), CPB, 1'b1);
    end
    fork
      begin
        model_byte(8'h05, 1'b1, 1'b1);
        send_byte(8'h05, CPB, 1'b1);
      end
      begin
        repeat (9 * CPB + CPB / 2 + 3) tick();
        rdy = 1'b1;
      end
    join
    drain("drain_simul");
    check("simul_ov", 32'(ov_cnt), 32'(exp_ov));

    // reset mid-byte discards FIFO and partial byte; then off-rate senders
    rdy = 1'b0;
    model_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h11, CPB, 1'b1);
    b = 8'h77;
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      repeat (CPB) tick();
    end
    rst     = 1'b1;
    uart_rx = 1'b1;
    exp_q.delete();
    repeat (3) tick();
    check("mid_rst_dat",   32'(rx_dat), 32'd0);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_fe",    32'(rx_frame_err), 32'd0);
    check("mid_rst_ov",    32'(rx_overrun), 32'd0);
    check("mid_rst_busy",  32'(rx_busy), 32'd0);
    rst = 1'b0;
    rdy = 1'b1;
    repeat (2 * CPB) tick();
    check("post_rst_valid", 32'(rx_valid), 32'd0);
    model_byte(8'hC6, 1'b1, 1'b0);
    send_byte(8'hC6, 100, 1'b1);
    repeat (20) tick();
    model_byte(8'h39, 1'b1, 1'b0);
    send_byte(8'h39, 108, 1'b1);
    drain("drain_rate");

    // random bytes, random gaps, randomly stalling consumer
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          b = 8'($urandom);
          model_byte(b, 1'b1, 1'b0);
          send_byte(b, CPB, 1'b1);
          repeat ($urandom_range(0, 40)) tick();
        end
        repeat (60) tick();
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          rdy = 1'($urandom_range(0, 1));
        end
        rdy = 1'b1;
      end
    join
    drain("drain_rand");
    check("final_fe", 32'(fe_cnt), 32'(exp_fe));
    check("final_ov", 32'(ov_cnt), 32'(exp_ov));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
